spike_rate_decoder: RTL and testbench

- Downstream readout stage for the LIF neuron layer.
- Consumes the per-neuron spike lines, counts spikes per channel over a programmable window, and reports the per-channel counts plus the winning (most active) channel.
- Reports with a one-cycle valid pulse.
- Converts the spiking output of the network into a classification usable by the pad logic or a host.

---
 rtl/spike_rate_decoder_if.sv | 38 +++
 rtl/spike_rate_decoder.sv | 143 ++++++++++++++
 tb/tb_spike_rate_decoder.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/spike_rate_decoder_if.sv
// Bus for spike_rate_decoder: run control and spike lines in, held counts and report strobe out.
// The tie output exists only when SPK_DECODER_TIE_EN is defined.
interface spike_rate_decoder_if #(
    parameter int N_CH  = 4,
    parameter int CNT_W = 4,
    parameter int WIN_W = 8
);
    localparam int IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1;

    logic                    enable;
    logic [WIN_W-1:0]        win_len;
    logic [N_CH-1:0]         spk_in;
    logic [N_CH*CNT_W-1:0]   count_out;
    logic [IDX_W-1:0]        winner;
    logic                    out_valid;
    logic                    busy;
`ifdef SPK_DECODER_TIE_EN
    logic                    tie;

    modport master (
        output enable, win_len, spk_in,
        input  count_out, winner, out_valid, busy, tie
    );
    modport slave (
        input  enable, win_len, spk_in,
        output count_out, winner, out_valid, busy, tie
    );
`else
    modport master (
        output enable, win_len, spk_in,
        input  count_out, winner, out_valid, busy
    );
    modport slave (
        input  enable, win_len, spk_in,
        output count_out, winner, out_valid, busy
    );
`endif
endinterface

// File: rtl/spike_rate_decoder.sv
// Windowed per-channel spike counter with argmax readout and a one-cycle report strobe.
// Optional feature macro: SPK_DECODER_TIE_EN adds a registered tie flag.
module spike_rate_decoder #(
    parameter int N_CH  = 4,
    parameter int CNT_W = 4,
    parameter int WIN_W = 8
) (
    input logic                  clk,
    input logic                  reset,
    spike_rate_decoder_if.slave  bus
);
    localparam int IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int VEC_W = N_CH * CNT_W;

    typedef enum logic [1:0] {
        S_IDLE,
        S_COUNT,
        S_REPORT
    } state_t;

    state_t           state_q, state_d;
    logic [WIN_W-1:0] win_q, win_d;
    logic [VEC_W-1:0] live_q, live_d, live_inc;
    logic [VEC_W-1:0] held_q, held_d;
    logic             start_ok;

    // Lowest index wins a tie because only a strictly larger count replaces the leader.
    function automatic logic [IDX_W-1:0] argmax(input logic [VEC_W-1:0] v);
        logic [CNT_W-1:0] best;
        logic [IDX_W-1:0] idx;
        best = v[CNT_W-1:0];
        idx  = '0;
        for (int i = 1; i < N_CH; i++) begin
            if (v[i*CNT_W +: CNT_W] > best) begin
                best = v[i*CNT_W +: CNT_W];
                idx  = IDX_W'(i);
            end
        end
        return idx;
    endfunction

    assign start_ok = bus.enable && (bus.win_len != '0);

    // Saturating increment of every channel that spiked this cycle.
    always_comb begin
        live_inc = live_q;
        for (int i = 0; i < N_CH; i++) begin
            if (bus.spk_in[i] && (live_q[i*CNT_W +: CNT_W] != {CNT_W{1'b1}})) begin
                live_inc[i*CNT_W +: CNT_W] = live_q[i*CNT_W +: CNT_W] + CNT_W'(1);
            end
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        live_d  = live_q;
        held_d  = held_q;
        unique case (state_q)
            S_IDLE: begin
                live_d = '0;
                if (start_ok) begin
                    win_d   = bus.win_len;
                    state_d = S_COUNT;
                end
            end
            S_COUNT: begin
                if (!bus.enable) begin
                    live_d  = '0;
                    state_d = S_IDLE;
                end else begin
                    live_d = live_inc;
                    win_d  = win_q - WIN_W'(1);
                    if (win_q == WIN_W'(1)) begin
                        held_d  = live_inc;
                        state_d = S_REPORT;
                    end
                end
            end
            S_REPORT: begin
                live_d = '0;
                if (start_ok) begin
                    win_d   = bus.win_len;
                    state_d = S_COUNT;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            win_q   <= '0;
            live_q  <= '0;
            held_q  <= '0;
        end else begin
            state_q <= state_d;
            win_q   <= win_d;
            live_q  <= live_d;
            held_q  <= held_d;
        end
    end

    assign bus.count_out = held_q;
    assign bus.winner    = argmax(held_q);
    assign bus.out_valid = (state_q == S_REPORT);
    assign bus.busy      = (state_q != S_IDLE);

`ifdef SPK_DECODER_TIE_EN
    logic tie_q;

    // True when two or more channels share the maximum, including all-zero.
    function automatic logic shared_max(input logic [VEC_W-1:0] v);
        logic [CNT_W-1:0] best;
        int               n;
        best = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (v[i*CNT_W +: CNT_W] > best) best = v[i*CNT_W +: CNT_W];
        end
        n = 0;
        for (int i = 0; i < N_CH; i++) begin
            if (v[i*CNT_W +: CNT_W] == best) n++;
        end
        return (n >= 2);
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tie_q <= 1'b0;
        end else if (state_q == S_COUNT && state_d == S_REPORT) begin
            tie_q <= shared_max(live_inc);
        end
    end

    assign bus.tie = tie_q;
`endif

endmodule

// File: tb/tb_spike_rate_decoder.sv
// Self-checking bench: directed scenarios with literal expectations plus a randomized run,
// all compared every cycle against a window-level behavioural model.
module tb_spike_rate_decoder;
    localparam int N_CH  = 4;
    localparam int CNT_W = 4;
    localparam int WIN_W = 8;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic clk;
    logic reset;

    spike_rate_decoder_if #(.N_CH(N_CH), .CNT_W(CNT_W), .WIN_W(WIN_W)) bus ();

    spike_rate_decoder #(.N_CH(N_CH), .CNT_W(CNT_W), .WIN_W(WIN_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total;
    int n_pass;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Behavioural model: phase 0 idle, 1 collecting a window, 2 reporting.
    int m_phase;
    int m_rem;
    int m_live[N_CH];
    int m_held[N_CH];
    bit m_tie;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_phase = 0;
            m_rem   = 0;
            m_tie   = 0;
            for (int i = 0; i < N_CH; i++) begin
                m_live[i] = 0;
                m_held[i] = 0;
            end
        end else begin
            case (m_phase)
                0, 2: begin
                    for (int i = 0; i < N_CH; i++) m_live[i] = 0;
                    if (bus.enable && bus.win_len != 0) begin
                        m_rem   = int'(bus.win_len);
                        m_phase = 1;
                    end else begin
                        m_phase = 0;
                    end
                end
                default: begin
                    if (!bus.enable) begin
                        for (int i = 0; i < N_CH; i++) m_live[i] = 0;
                        m_phase = 0;
                    end else begin
                        for (int i = 0; i < N_CH; i++)
                            if (bus.spk_in[i] && m_live[i] < CMAX) m_live[i]++;
                        m_rem--;
                        if (m_rem == 0) begin
                            int mx, n;
                            mx = 0;
                            n  = 0;
                            for (int i = 0; i < N_CH; i++) begin
                                m_held[i] = m_live[i];
                                if (m_live[i] > mx) mx = m_live[i];
                            end
                            for (int i = 0; i < N_CH; i++) if (m_live[i] == mx) n++;
                            m_tie   = (n >= 2);
                            m_phase = 2;
                        end
                    end
                end
            endcase
        end
    end

    function automatic logic [31:0] exp_count();
        logic [31:0] v;
        v = '0;
        for (int i = 0; i < N_CH; i++) v[i*CNT_W +: CNT_W] = CNT_W'(m_held[i]);
        return v;
    endfunction

    function automatic logic [31:0] exp_winner();
        int best, idx;
        best = -1;
        idx  = 0;
        for (int i = 0; i < N_CH; i++) begin
            if (m_held[i] > best) begin
                best = m_held[i];
                idx  = i;
            end
        end
        return 32'(idx);
    endfunction

    task automatic compare();
        check("count_out", 32'(bus.count_out), exp_count());
        check("winner", 32'(bus.winner), exp_winner());
        check("out_valid", 32'(bus.out_valid), 32'(m_phase == 2));
        check("busy", 32'(bus.busy), 32'(m_phase != 0));
`ifdef SPK_DECODER_TIE_EN
        check("tie", 32'(bus.tie), 32'(m_tie));
`endif
    endtask

    task automatic drive(input logic en, input logic [WIN_W-1:0] wl, input logic [N_CH-1:0] spk);
        @(negedge clk);
        bus.enable  = en;
        bus.win_len = wl;
        bus.spk_in  = spk;
    endtask

    // Called after the last spike of a window has been driven.
    task automatic finish_window(input string name, input logic [31:0] cnt, input logic [31:0] win);
        @(negedge clk);
        check({name, "_valid"}, 32'(bus.out_valid), 32'd1);
        check({name, "_count"}, 32'(bus.count_out), cnt);
        check({name, "_winner"}, 32'(bus.winner), win);
        bus.enable = 1'b0;
        bus.spk_in = '0;
        @(negedge clk);
        check({name, "_idle_busy"}, 32'(bus.busy), 32'd0);
        check({name, "_idle_valid"}, 32'(bus.out_valid), 32'd0);
    endtask

    task automatic wait_idle(input string name);
        int k;
        bus.enable = 1'b0;
        k = 0;
        while (bus.busy && k < 60) begin
            @(negedge clk);
            k++;
        end
        check({name, "_idle_timeout"}, 32'(bus.busy), 32'd0);
    endtask

    initial begin
        int pulses;
        bus.enable  = 1'b0;
        bus.win_len = '0;
        bus.spk_in  = '0;
        n_total     = 0;
        n_pass      = 0;
        reset       = 1'b0;
        #1 reset = 1'b1;
        #2;
        check("rst_count", 32'(bus.count_out), 32'd0);
        check("rst_winner", 32'(bus.winner), 32'd0);
        check("rst_valid", 32'(bus.out_valid), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        fork
            forever begin
                @(negedge clk);
                if (!reset) compare();
            end
        join_none

        // win_len=0 never starts a window.
        repeat (3) drive(1'b1, 8'd0, 4'b1111);
        @(negedge clk);
        check("zero_len_busy", 32'(bus.busy), 32'd0);
        bus.enable = 1'b0;

        // Basic window: ch0 every cycle, ch2 on 3 of 5 cycles.
        drive(1'b1, 8'd5, 4'b0000);
        for (int k = 1; k <= 5; k++) drive(1'b1, 8'd5, (k % 2 == 1) ? 4'b0101 : 4'b0001);
        finish_window("basic", 32'h0305, 32'd0);

        // Saturation.
        drive(1'b1, 8'd20, 4'b0010);
        for (int k = 1; k <= 20; k++) drive(1'b1, 8'd20, 4'b0010);
        finish_window("sat", 32'h00F0, 32'd1);

        // Tie between ch1 and ch3.
        drive(1'b1, 8'd8, 4'b0000);
        for (int k = 1; k <= 8; k++) drive(1'b1, 8'd8, (k <= 4) ? 4'b0010 : 4'b1000);
        finish_window("tie", 32'h4040, 32'd1);
`ifdef SPK_DECODER_TIE_EN
        check("tie_flag", 32'(bus.tie), 32'd1);
`endif
        drive(1'b1, 8'd8, 4'b0000);
        for (int k = 1; k <= 8; k++) drive(1'b1, 8'd8, 4'b0000);
        finish_window("zero", 32'h0000, 32'd0);
`ifdef SPK_DECODER_TIE_EN
        check("zero_tie_flag", 32'(bus.tie), 32'd1);
`endif

        // Back-to-back windows; spikes during REPORT are ignored.
        pulses = 0;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            if (bus.out_valid) pulses++;
            bus.enable  = 1'b1;
            bus.win_len = 8'd3;
            bus.spk_in  = 4'b0100;
        end
        @(negedge clk);
        if (bus.out_valid) pulses++;
        check("b2b_pulses", 32'(pulses), 32'd4);
        check("b2b_count", 32'(bus.count_out), 32'h0300);
        bus.enable = 1'b0;
        wait_idle("b2b");

        // Abort after three counting edges; held results survive.
        drive(1'b1, 8'd10, 4'b0000);
        for (int k = 1; k <= 3; k++) drive(1'b1, 8'd10, 4'($urandom_range(0, 15)));
        drive(1'b0, 8'd10, 4'b1111);
        @(negedge clk);
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_count", 32'(bus.count_out), 32'h0300);
        check("abort_winner", 32'(bus.winner), 32'd2);

        // Asynchronous reset mid-window.
        drive(1'b1, 8'd10, 4'b1111);
        for (int k = 1; k <= 3; k++) drive(1'b1, 8'd10, 4'b1111);
        @(posedge clk);
        #3 reset = 1'b1;
        #1;
        check("arst_count", 32'(bus.count_out), 32'd0);
        check("arst_winner", 32'(bus.winner), 32'd0);
        check("arst_busy", 32'(bus.busy), 32'd0);
        @(negedge clk);
        reset       = 1'b0;
        bus.enable  = 1'b1;
        bus.win_len = 8'd2;
        bus.spk_in  = 4'b0000;
        drive(1'b1, 8'd2, 4'b0011);
        drive(1'b1, 8'd2, 4'b0011);
        finish_window("post_rst", 32'h0022, 32'd0);

        // Randomized run against the model.
        for (int k = 0; k < 600; k++)
            drive(($urandom_range(0, 19) != 0), 8'($urandom_range(0, 12)), 4'($urandom_range(0, 15)));
        @(negedge clk);
        wait_idle("rand");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule
